// File: rtl/linearizer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : linearizer_scheduler
// Purpose  : Time-multiplexes one shared combinational Linearizer between
//            CHANNELS requesting oscillator channels. Round-robin arbitration,
//            registered drive of the Linearizer inputs, one-cycle result
//            capture into per-channel response slots, and settle bubbles
//            whenever the Linearizer mode_close select must change.
// Ports    : clk, reset                      - clock / sync active-high reset
//            req_valid/req_in/req_mode_close - per-channel requests (held)
//            req_ready                       - one-hot accept strobe
//            lin_in/lin_mode_close           - registered Linearizer drive
//            lin_result                      - Linearizer combinational result
//            rsp_valid/rsp_result/rsp_ready  - per-channel response slots
//            err                             - sticky per-channel range error
// Options  : LIN_RANGE_CHECK_EN - when defined, accepted inputs >= 3584 are
//            clamped to 3583 and flag err[channel]; otherwise err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module linearizer_scheduler #(
    parameter int CHANNELS      = 4,
    parameter int DW            = 13,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    req_valid,
    input  logic [CHANNELS*DW-1:0] req_in,
    input  logic [CHANNELS-1:0]    req_mode_close,
    output logic [CHANNELS-1:0]    req_ready,
    output logic [DW-1:0]          lin_in,
    output logic                   lin_mode_close,
    input  logic [DW-1:0]          lin_result,
    output logic [CHANNELS-1:0]    rsp_valid,
    output logic [CHANNELS*DW-1:0] rsp_result,
    input  logic [CHANNELS-1:0]    rsp_ready,
    output logic [CHANNELS-1:0]    err
);

    localparam int c_cw = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [c_cw:0]   c_num_ch      = (c_cw+1)'(CHANNELS);
    localparam logic [c_cw-1:0] c_last_ch     = c_cw'(CHANNELS - 1);
    localparam logic [c_cw-1:0] c_one_idx     = c_cw'(1);
    localparam logic [3:0]      c_settle_init = 4'(SETTLE_CYCLES);

    localparam logic [0:0] c_st_run    = 1'b0;
    localparam logic [0:0] c_st_settle = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [c_cw-1:0]     r_rr;
    logic [3:0]          r_settle_cnt;
    logic [DW-1:0]       r_lin_in;
    logic                r_lin_mode_close;
    logic                r_cap_valid;     // a result is on lin_result this cycle
    logic [c_cw-1:0]     r_cap_ch;        // channel that owns that result
    logic [CHANNELS-1:0] r_rsp_valid;
    logic [DW-1:0]       r_rsp_result [CHANNELS];

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic [DW-1:0]       w_req_data [CHANNELS];
    logic [CHANNELS-1:0] w_eligible;
    logic [c_cw:0]       w_sum;
    logic                w_found;
    logic [c_cw-1:0]     w_grant;
    logic                w_grant_mode;
    logic                w_mode_match;
    logic                w_accept;
    logic                w_switch;
    logic [c_cw-1:0]     w_rr_next;
    logic [DW-1:0]       w_lin_in_next;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            localparam logic [c_cw-1:0] c_idx = c_cw'(i);

            assign w_req_data[i] = req_in[i*DW +: DW];

            // A channel with a full slot or a result still in the capture
            // stage must wait; one outstanding request per channel.
            assign w_eligible[i] = req_valid[i] & ~r_rsp_valid[i]
                                 & ~(r_cap_valid & (r_cap_ch == c_idx));

            assign rsp_result[i*DW +: DW] = r_rsp_result[i];
        end
    endgenerate

    // Round-robin search: first eligible channel at or after r_rr.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_sum = {1'b0, r_rr} + (c_cw+1)'(k);
            if (w_sum >= c_num_ch) begin
                w_sum = w_sum - c_num_ch;
            end
            if (!w_found && w_eligible[w_sum[c_cw-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_sum[c_cw-1:0];
            end
        end
    end

    assign w_grant_mode = req_mode_close[w_grant];
    assign w_mode_match = (w_grant_mode == r_lin_mode_close);

    // reset gates the strobe so no accept is advertised while held in reset.
    assign w_accept = ~reset & (r_state == c_st_run) & w_found &  w_mode_match;
    assign w_switch = ~reset & (r_state == c_st_run) & w_found & ~w_mode_match;

    assign w_rr_next = (w_grant == c_last_ch) ? '0 : (w_grant + c_one_idx);

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

`ifdef LIN_RANGE_CHECK_EN
    localparam logic [DW-1:0] c_range_lim = DW'(3584);
    localparam logic [DW-1:0] c_range_max = DW'(3583);

    logic                w_over;
    logic [CHANNELS-1:0] r_err;

    assign w_over        = (w_req_data[w_grant] >= c_range_lim);
    assign w_lin_in_next = w_over ? c_range_max : w_req_data[w_grant];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else if (w_accept && w_over) begin
            r_err[w_grant] <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_lin_in_next = w_req_data[w_grant];
    assign err           = '0;
`endif

    // ------------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_st_run;
            r_rr             <= '0;
            r_settle_cnt     <= '0;
            r_lin_in         <= '0;
            r_lin_mode_close <= 1'b1;
            r_cap_valid      <= 1'b0;
            r_cap_ch         <= '0;
            r_rsp_valid      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_rsp_result[i] <= '0;
            end
        end else begin
            r_cap_valid <= w_accept;
            r_cap_ch    <= w_grant;

            if (w_accept) begin
                r_lin_in <= w_lin_in_next;
                r_rr     <= w_rr_next;
            end

            case (r_state)
                c_st_run: begin
                    // Pointer is left alone so the same channel wins once the
                    // Linearizer has settled in its requested mode.
                    if (w_switch) begin
                        r_lin_mode_close <= w_grant_mode;
                        r_settle_cnt     <= c_settle_init;
                        r_state          <= c_st_settle;
                    end
                end
                c_st_settle: begin
                    if (r_settle_cnt <= 4'd1) begin
                        r_settle_cnt <= '0;
                        r_state      <= c_st_run;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= c_st_run;
                end
            endcase

            // Ack clears a slot; a capture into the same slot cannot coincide
            // because a full slot blocks eligibility.
            r_rsp_valid <= r_rsp_valid & ~rsp_ready;
            if (r_cap_valid) begin
                r_rsp_valid[r_cap_ch]  <= 1'b1;
                r_rsp_result[r_cap_ch] <= lin_result;
            end
        end
    end

    assign lin_in         = r_lin_in;
    assign lin_mode_close = r_lin_mode_close;
    assign rsp_valid      = r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_linearizer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_linearizer_scheduler
// Purpose  : Directed self-checking bench for linearizer_scheduler with a
//            behavioural Linearizer stand-in and a response scoreboard.
// Options  : LIN_RANGE_CHECK_EN - selects clamped/unclamped expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_linearizer_scheduler;

    localparam int CH = 4;
    localparam int W  = 13;

`ifdef LIN_RANGE_CHECK_EN
    localparam logic [3:0] EXP_ERR3 = 4'b1000;
`else
    localparam logic [3:0] EXP_ERR3 = 4'b0000;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   req_valid;
    logic [CH*W-1:0] req_in;
    logic [CH-1:0]   req_mode_close;
    logic [CH-1:0]   req_ready;
    logic [W-1:0]    lin_in;
    logic            lin_mode_close;
    logic [W-1:0]    lin_result;
    logic [CH-1:0]   rsp_valid;
    logic [CH*W-1:0] rsp_result;
    logic [CH-1:0]   rsp_ready;
    logic [CH-1:0]   err;

    int n_vec = 0;
    int n_err = 0;

    int           sb_ch [$];
    logic [W-1:0] sb_val[$];
    logic [CH-1:0] prev_v = '0;
    int           hit;

    always #5 clk = ~clk;

    // Stand-in for the shared Linearizer: distinct transfer per mode.
    function automatic logic [W-1:0] lin_model(input logic [W-1:0] x, input logic m);
        logic [W-1:0] r;
        if (m) r = x * 13'd5 + 13'd17;
        else   r = {x[0], x[W-1:1]} ^ 13'h0ABC;
        return r;
    endfunction

    function automatic logic [W-1:0] exp_lin_in(input logic [W-1:0] x);
`ifdef LIN_RANGE_CHECK_EN
        return (x >= 13'd3584) ? 13'd3583 : x;
`else
        return x;
`endif
    endfunction

    always_comb lin_result = lin_model(lin_in, lin_mode_close);

    linearizer_scheduler #(
        .CHANNELS      (CH),
        .DW            (W),
        .SETTLE_CYCLES (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_in         (req_in),
        .req_mode_close (req_mode_close),
        .req_ready      (req_ready),
        .lin_in         (lin_in),
        .lin_mode_close (lin_mode_close),
        .lin_result     (lin_result),
        .rsp_valid      (rsp_valid),
        .rsp_result     (rsp_result),
        .rsp_ready      (rsp_ready),
        .err            (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int ch, input logic [W-1:0] x, input logic m, input bit push);
        req_valid[ch]        = 1'b1;
        req_in[ch*W +: W]    = x;
        req_mode_close[ch]   = m;
        if (push) begin
            sb_ch.push_back(ch);
            sb_val.push_back(lin_model(exp_lin_in(x), m));
        end
    endtask

    // Scoreboard: every new rsp_valid rise must match the oldest pending
    // expectation for that channel.
    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (!reset && rsp_valid[i] && !prev_v[i]) begin
                hit = -1;
                for (int j = 0; j < sb_ch.size(); j++) begin
                    if (hit < 0 && sb_ch[j] == i) hit = j;
                end
                if (hit < 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL rsp_unexpected ch%0d: observed rsp_valid 1 expected 0", i);
                end else begin
                    check($sformatf("rsp_result ch%0d", i), 64'(rsp_result[i*W +: W]), 64'(sb_val[hit]));
                    sb_ch.delete(hit);
                    sb_val.delete(hit);
                end
            end
        end
        prev_v = reset ? '0 : rsp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH-1:0] onehot;

        // ---------------- reset defaults, all channels requesting -----------
        reset          = 1'b1;
        rsp_ready      = 4'hF;
        req_valid      = '0;
        req_in         = '0;
        req_mode_close = '0;
        for (int i = 0; i < CH; i++) drive_req(i, 13'((i + 1) * 100), 1'b1, 1'b1);

        step(); #1;
        check("rst1_req_ready", 64'(req_ready), 64'h0);
        check("rst1_mode",      64'(lin_mode_close), 64'h1);
        check("rst1_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst1_lin_in",    64'(lin_in), 64'h0);
        check("rst1_err",       64'(err), 64'h0);
        step(); #1;
        check("rst2_req_ready", 64'(req_ready), 64'h0);
        check("rst2_rsp_valid", 64'(rsp_valid), 64'h0);
        reset = 1'b0;

        // ---------------- round-robin, same mode ----------------------------
        for (int i = 0; i < CH; i++) begin
            if (i > 0) begin
                step();
                req_valid[i-1] = 1'b0;
            end
            #1;
            onehot = 4'b0001 << i;
            check($sformatf("rr_ready_%0d", i), 64'(req_ready), 64'(onehot));
            check($sformatf("rr_lin_in_%0d", i), 64'(lin_in),
                  (i > 0) ? 64'(exp_lin_in(13'(i * 100))) : 64'h0);
            check($sformatf("rr_rsp_valid_%0d", i), 64'(rsp_valid),
                  (i >= 2) ? 64'(4'b0001 << (i - 2)) : 64'h0);
        end
        step(); req_valid[3] = 1'b0; #1;
        check("rr_idle_ready",  64'(req_ready), 64'h0);
        check("rr_lin_in_3",    64'(lin_in), 64'd400);
        check("rr_rsp_valid_2", 64'(rsp_valid), 64'h4);
        step(); #1;
        check("rr_rsp_valid_3", 64'(rsp_valid), 64'h8);
        step(); #1;
        check("rr_rsp_drained", 64'(rsp_valid), 64'h0);

        // ---------------- mode switch, SETTLE_CYCLES = 3 --------------------
        drive_req(0, 13'd1000, 1'b0, 1'b1); #1;
        check("ms_decide_ready", 64'(req_ready), 64'h0);
        check("ms_decide_mode",  64'(lin_mode_close), 64'h1);
        step(); #1;
        check("ms_mode_new",     64'(lin_mode_close), 64'h0);
        check("ms_bubble1",      64'(req_ready), 64'h0);
        step(); #1;
        check("ms_bubble2",      64'(req_ready), 64'h0);
        step(); #1;
        check("ms_bubble3",      64'(req_ready), 64'h0);
        step(); #1;
        check("ms_accept",       64'(req_ready), 64'h1);
        step(); req_valid[0] = 1'b0; #1;
        check("ms_lin_in",       64'(lin_in), 64'd1000);
        step(); #1;
        check("ms_rsp_valid",    64'(rsp_valid), 64'h1);

        // ---------------- backpressure on ch1 -------------------------------
        step();
        rsp_ready = 4'b1101;
        drive_req(1, 13'd500, 1'b0, 1'b1); #1;
        check("bp_grant1",       64'(req_ready), 64'h2);
        step(); req_valid[1] = 1'b0; #1;
        check("bp_idle",         64'(req_ready), 64'h0);
        step(); #1;
        check("bp_slot_full",    64'(rsp_valid), 64'h2);
        drive_req(1, 13'd600, 1'b0, 1'b1);
        drive_req(2, 13'd700, 1'b0, 1'b1);
        drive_req(3, 13'd800, 1'b0, 1'b1); #1;
        check("bp_grant2",       64'(req_ready), 64'h4);
        step(); req_valid[2] = 1'b0; #1;
        check("bp_grant3",       64'(req_ready), 64'h8);
        step(); req_valid[3] = 1'b0; #1;
        check("bp_ch1_blocked",  64'(req_ready), 64'h0);
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            check($sformatf("bp_hold_ready_%0d", k), 64'(req_ready), 64'h0);
            check($sformatf("bp_hold_valid_%0d", k), 64'(rsp_valid[1]), 64'h1);
            check($sformatf("bp_hold_data_%0d", k), 64'(rsp_result[W +: W]),
                  64'(lin_model(13'd500, 1'b0)));
        end
        step(); rsp_ready = 4'hF; #1;
        check("bp_ack_no_bypass", 64'(req_ready), 64'h0);
        step(); #1;
        check("bp_regrant",      64'(req_ready), 64'h2);
        check("bp_slot_cleared", 64'(rsp_valid[1]), 64'h0);
        step(); req_valid[1] = 1'b0; #1;
        check("bp_lin_in",       64'(lin_in), 64'd600);
        step(); #1;
        check("bp_rsp_valid",    64'(rsp_valid[1]), 64'h1);

        // ---------------- reset mid-flight ----------------------------------
        step();
        drive_req(2, 13'd900, 1'b0, 1'b0); #1;
        check("rmf_grant",       64'(req_ready), 64'h4);
        step(); reset = 1'b1; req_valid = '0; #1;
        check("rmf_lin_in",      64'(lin_in), 64'd900);
        step(); #1;
        check("rmf_ready",       64'(req_ready), 64'h0);
        check("rmf_lin_in_rst",  64'(lin_in), 64'h0);
        check("rmf_mode",        64'(lin_mode_close), 64'h1);
        check("rmf_rsp_valid",   64'(rsp_valid), 64'h0);
        check("rmf_rsp_result",  64'(rsp_result), 64'h0);
        check("rmf_err",         64'(err), 64'h0);
        step(); reset = 1'b0; #1;
        check("rmf_no_pulse_a",  64'(rsp_valid), 64'h0);
        step(); #1;
        check("rmf_no_pulse_b",  64'(rsp_valid), 64'h0);

        // ---------------- range check and pointer wrap ----------------------
        drive_req(3, 13'd4000, 1'b1, 1'b1); #1;
        check("rc_grant3",       64'(req_ready), 64'h8);
        step(); req_valid[3] = 1'b0; #1;
        check("rc_lin_in",       64'(lin_in), 64'(exp_lin_in(13'd4000)));
        check("rc_err",          64'(err), 64'(EXP_ERR3));
        step();
        drive_req(0, 13'd50, 1'b1, 1'b1); #1;
        check("rc_wrap_grant0",  64'(req_ready), 64'h1);
        step(); req_valid[0] = 1'b0; #1;
        check("rc_lin_in_small", 64'(lin_in), 64'd50);
        check("rc_err_sticky_a", 64'(err), 64'(EXP_ERR3));
        step(); step(); #1;
        check("rc_err_sticky_b", 64'(err), 64'(EXP_ERR3));
        check("sb_empty",        64'(sb_ch.size()), 64'h0);
        reset = 1'b1;
        step(); #1;
        check("rc_err_cleared",  64'(err), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
